dmux_stream: RTL and testbench
==============================

Name: dmux_stream

Overview:
- Parametrised, registered 1-to-NUM_CH stream demultiplexer. Successor to the combinational 1-bit/2-way Dmux.
- Routes WIDTH-bit words from one valid/ready source to the channel named by in_sel, through a single output register with backpressure.
- Intended as the write-routing stage in front of the Hack memory-mapped targets (RAM, SCREEN, KBD, spare).
- Out-of-range selects are dropped and flagged; accepted and dropped words are counted.

Parameters:
- WIDTH, 16, data word width in bits (≥1).
- NUM_CH, 4, number of output channels (2..16).
- SEL_W, 2, width of in_sel. Must satisfy 2^SEL_W ≥ NUM_CH.
- CNT_W, 16, width of the transfer and drop counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  source word present.
- in_ready  output  1  block can accept the word this cycle.
- in_data  input  WIDTH  source word.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  NUM_CH  one-hot valid; bit k means the word is for channel k.
- out_ready  input  NUM_CH  per-channel ready from the sinks.
- out_data  output  WIDTH  registered word, shared by all channels.
- sel_err  output  1  sticky; set by the first out-of-range select accepted.
- xfer_count  output  CNT_W  number of words delivered to any channel.
- drop_count  output  CNT_W  number of words dropped for a bad select.
- clear  input  1  synchronous; zeroes sel_err, xfer_count and drop_count.

Behaviour:
- Reset (async, active-high, effective immediately, takes priority over everything):
  - out_valid=0, out_data=0, sel_err=0, xfer_count=0, drop_count=0.
  - Internal held flag and held_sel cleared.
  - Any word held at reset assertion is lost and not counted.
- Storage: one holding register (data, sel, held flag). No other buffering.
- Output decode: out_valid = held ? (1 << held_sel) : 0. At most one bit is ever set.
- Drain: drain = held && out_ready[held_sel]. out_ready bits of non-selected channels are ignored.
- Input ready: in_ready = !held || drain (combinational). This gives full throughput of 1 word/clk when the sink stays ready.
- Accept: accept = in_valid && in_ready. Latency from accept to out_valid is exactly 1 cycle.
- Good select (in_sel < NUM_CH), on accept:
  - Register in_data and in_sel; held=1 next cycle.
  - If a drain happens in the same cycle, the new word replaces the old one with no bubble.
- Bad select (in_sel ≥ NUM_CH), on accept:
  - Word is consumed (in_ready honoured) but not stored.
  - drop_count += 1, sel_err <= 1.
  - held <= 0 if a drain occurred this cycle, otherwise held is unchanged.
- On drain: xfer_count += 1. If there is no good accept in the same cycle, held <= 0.
- out_data retains the last word after a drain. It is only meaningful while out_valid != 0.
- Stability: while held and not drained, out_data and out_valid must not change (AXI-style stability).
- Counters saturate at 2^CNT_W−1; no wrap.
- clear vs. events in the same cycle: clear wins; the counter or flag reads 0 the next cycle.
- Source contract: in_valid must stay high with data/sel stable until accepted. The block does not check this.
- NUM_CH = 2^SEL_W: no bad select is possible; sel_err and drop_count stay 0.

Test Plan:
1. Reset, then in_valid=1, in_data=16'hA5A5, in_sel=2, all out_ready=1 → next cycle out_valid=4'b0100, out_data=16'hA5A5; xfer_count=1 one cycle later.
2. Back-to-back stream: 8 words, sels 0,1,2,3,0,1,2,3, all sinks ready → in_ready held at 1 throughout; out_valid follows one-hot 0001,0010,0100,1000,… with 1-cycle lag; xfer_count=8.
3. Backpressure: word 16'h1234 to ch1 with out_ready[1]=0 and out_ready[0,2,3]=1 for 5 cycles → in_ready=0, out_valid=4'b0010 and out_data stable for all 5 cycles; raise out_ready[1] → drains in that cycle, xfer_count=1.
4. NUM_CH=3, SEL_W=2: send sel=3, data=16'hFFFF → no out_valid, drop_count=1, sel_err=1. Then clear=1 → both read 0 the following cycle.
5. Reset mid-operation: word held with out_ready=0, assert reset asynchronously between clock edges → out_valid=0, out_data=0 immediately; xfer_count=0 after release.
6. Saturation, CNT_W=4: 20 good transfers → xfer_count stops at 15; a drain together with clear in the same cycle → xfer_count=0.

Source files
------------

// File: rtl/dmux_stream.sv
`default_nettype none
// ============================================================================
// Module      : dmux_stream
// Description : Registered 1-to-NUM_CH valid/ready stream demultiplexer.
//               A single holding register routes each word to the channel
//               named by in_sel; out-of-range selects are dropped, flagged
//               and counted alongside delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_stream #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              sel_err,
    output logic [CNT_W-1:0]  xfer_count,
    output logic [CNT_W-1:0]  drop_count,
    input  logic              clear
);

    logic              held;
    logic [SEL_W-1:0]  held_sel;
    logic [NUM_CH-1:0] sel_onehot;
    logic              drain;
    logic              accept;
    logic              sel_good;
    logic              good_acc;
    logic              bad_acc;

    // One-hot decode of the held channel; only ever one bit can match.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_onehot
        assign sel_onehot[k] = (held_sel == SEL_W'(k));
    end

    // Only the selected sink's ready can drain the word; others are ignored.
    assign drain     = held && |(sel_onehot & out_ready);
    assign out_valid = held ? sel_onehot : '0;
    assign in_ready  = !held || drain;
    assign accept    = in_valid && in_ready;
    assign sel_good  = (32'(in_sel) < 32'(NUM_CH));
    assign good_acc  = accept && sel_good;
    assign bad_acc   = accept && !sel_good;

    // Holding register: a good accept refills (even while draining, no bubble);
    // a drain without refill empties it; a bad accept leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held     <= 1'b0;
            held_sel <= '0;
            out_data <= '0;
        end else begin
            if (good_acc) begin
                held     <= 1'b1;
                held_sel <= in_sel;
                out_data <= in_data;
            end else if (drain) begin
                held     <= 1'b0;
            end
        end
    end

    // Delivered-word counter, saturating; clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (clear) begin
            xfer_count <= '0;
        end else if (drain && (xfer_count != {CNT_W{1'b1}})) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end

    // Dropped-word counter, saturating; clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (clear) begin
            drop_count <= '0;
        end else if (bad_acc && (drop_count != {CNT_W{1'b1}})) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    // Sticky bad-select flag; clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (clear) begin
            sel_err <= 1'b0;
        end else if (bad_acc) begin
            sel_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmux_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux_stream
// Description : Scoreboard bench for dmux_stream. Three instances share the
//               stimulus: default (4 ch), 3-channel, and 4-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic [3:0]  out_ready = '0;
    logic        clear = 1'b0;

    logic        a_in_ready, a_sel_err;
    logic [3:0]  a_out_valid;
    logic [15:0] a_out_data, a_xfer, a_drop;
    logic        b_in_ready, b_sel_err;
    logic [2:0]  b_out_valid;
    logic [15:0] b_out_data, b_xfer, b_drop;
    logic        c_in_ready, c_sel_err;
    logic [3:0]  c_out_valid;
    logic [15:0] c_out_data;
    logic [3:0]  c_xfer, c_drop;

    int n_cmp = 0;
    int n_err = 0;
    bit sb_en = 1'b0;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  sel;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmux_stream u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .sel_err(a_sel_err),
        .xfer_count(a_xfer), .drop_count(a_drop), .clear(clear));

    dmux_stream #(.NUM_CH(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(b_out_valid),
        .out_ready(out_ready[2:0]), .out_data(b_out_data), .sel_err(b_sel_err),
        .xfer_count(b_xfer), .drop_count(b_drop), .clear(clear));

    dmux_stream #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_data(c_out_data), .sel_err(c_sel_err),
        .xfer_count(c_xfer), .drop_count(c_drop), .clear(clear));

    // Scoreboard monitor on the default instance: a drain is pending whenever
    // the valid channel's ready is up at the sampling edge.
    always @(negedge clk) begin
        if (sb_en && !reset && (|(a_out_valid & out_ready))) begin
            exp_t e;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: out_valid=%b out_data=%h, required no output", a_out_valid, a_out_data);
            end else begin
                e = sb.pop_front();
                if (a_out_valid !== (4'b0001 << e.sel) || a_out_data !== e.data) begin
                    n_err++;
                    $display("FAIL sb_word: out_valid=%b out_data=%h, required %b / %h",
                             a_out_valid, a_out_data, 4'b0001 << e.sel, e.data);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
    endtask

    // Present one word and hold it until accepted (bounded), then scoreboard it.
    task automatic send(input logic [15:0] d, input logic [1:0] s);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 20 cycles", a_in_ready);
        end else if (sb_en) begin
            sb.push_back('{data: d, sel: s});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d words left, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (a_out_valid !== 4'b0 || a_out_data !== 16'h0 || a_sel_err !== 1'b0 ||
            a_xfer !== 16'h0 || a_drop !== 16'h0 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: ov=%b od=%h err=%b xc=%0d dc=%0d rdy=%b, required 0/0/0/0/0/1",
                     a_out_valid, a_out_data, a_sel_err, a_xfer, a_drop, a_in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        sb_en = 1'b1;
        out_ready = 4'b1111;
        send(16'hA5A5, 2'd2);
        @(negedge clk);
        n_cmp++;
        if (a_out_valid !== 4'b0100 || a_out_data !== 16'hA5A5) begin
            n_err++;
            $display("FAIL single_out: ov=%b od=%h, required 0100 / a5a5", a_out_valid, a_out_data);
        end
        @(negedge clk);
        n_cmp++;
        if (a_xfer !== 16'd1 || a_out_valid !== 4'b0) begin
            n_err++;
            $display("FAIL single_count: xfer=%0d ov=%b, required 1 / 0000", a_xfer, a_out_valid);
        end
        wait_empty();
    endtask

    task automatic test_back_to_back();
        bit rdy_ok = 1'b1;
        do_reset();
        sb_en = 1'b1;
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (!a_in_ready) rdy_ok = 1'b0;
            send(16'h1000 + 16'(i), 2'(i % 4));
            if (!a_in_ready) rdy_ok = 1'b0;
        end
        n_cmp++;
        if (!rdy_ok) begin
            n_err++;
            $display("FAIL b2b_ready: in_ready dropped, required 1 throughout");
        end
        wait_empty();
        @(negedge clk);
        n_cmp++;
        if (a_xfer !== 16'd8) begin
            n_err++;
            $display("FAIL b2b_count: xfer=%0d, required 8", a_xfer);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        sb_en = 1'b1;
        out_ready = 4'b1101;
        send(16'h1234, 2'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 4'b0010 || a_out_data !== 16'h1234) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: rdy=%b ov=%b od=%h, required 0 / 0010 / 1234",
                         i, a_in_ready, a_out_valid, a_out_data);
            end
        end
        @(posedge clk);
        #1 out_ready = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: rdy=%b, required 1", a_in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (a_xfer !== 16'd1 || a_out_valid !== 4'b0) begin
            n_err++;
            $display("FAIL bp_count: xfer=%0d ov=%b, required 1 / 0000", a_xfer, a_out_valid);
        end
        wait_empty();
    endtask

    task automatic test_bad_sel();
        do_reset();
        sb_en = 1'b0;
        out_ready = 4'b1111;
        send(16'hFFFF, 2'd3);
        @(negedge clk);
        n_cmp++;
        if (b_out_valid !== 3'b0 || b_drop !== 16'd1 || b_sel_err !== 1'b1 || b_xfer !== 16'd0) begin
            n_err++;
            $display("FAIL bad_drop: ov=%b drop=%0d err=%b xfer=%0d, required 000 / 1 / 1 / 0",
                     b_out_valid, b_drop, b_sel_err, b_xfer);
        end
        n_cmp++;
        if (a_sel_err !== 1'b0 || a_drop !== 16'd0) begin
            n_err++;
            $display("FAIL full_range: err=%b drop=%0d, required 0 / 0", a_sel_err, a_drop);
        end
        // Good word, then a bad word accepted in the cycle the good one drains.
        @(posedge clk);
        #1;
        send(16'h0202, 2'd2);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        in_sel   = 2'd3;
        @(negedge clk);
        n_cmp++;
        if (b_out_valid !== 3'b100 || b_out_data !== 16'h0202 || b_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bad_good_word: ov=%b od=%h rdy=%b, required 100 / 0202 / 1",
                     b_out_valid, b_out_data, b_in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_out_valid !== 3'b0 || b_drop !== 16'd2 || b_xfer !== 16'd1) begin
            n_err++;
            $display("FAIL bad_with_drain: ov=%b drop=%0d xfer=%0d, required 000 / 2 / 1",
                     b_out_valid, b_drop, b_xfer);
        end
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_drop !== 16'd0 || b_sel_err !== 1'b0 || b_xfer !== 16'd0) begin
            n_err++;
            $display("FAIL bad_clear: drop=%0d err=%b xfer=%0d, required 0 / 0 / 0", b_drop, b_sel_err, b_xfer);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sb_en = 1'b0;
        out_ready = 4'b0000;
        send(16'h5A5A, 2'd0);
        @(negedge clk);
        n_cmp++;
        if (a_out_valid !== 4'b0001 || a_out_data !== 16'h5A5A) begin
            n_err++;
            $display("FAIL mid_held: ov=%b od=%h, required 0001 / 5a5a", a_out_valid, a_out_data);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (a_out_valid !== 4'b0 || a_out_data !== 16'h0 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_async: ov=%b od=%h rdy=%b, required 0000 / 0000 / 1",
                     a_out_valid, a_out_data, a_in_ready);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        out_ready = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (a_xfer !== 16'd0 || a_out_valid !== 4'b0) begin
            n_err++;
            $display("FAIL mid_after: xfer=%0d ov=%b, required 0 / 0000", a_xfer, a_out_valid);
        end
        sb.delete();
    endtask

    task automatic test_saturation();
        do_reset();
        sb_en = 1'b1;
        out_ready = 4'b1111;
        for (int i = 0; i < 20; i++) send(16'h2000 + 16'(i), 2'(i % 4));
        wait_empty();
        @(negedge clk);
        n_cmp++;
        if (c_xfer !== 4'd15 || a_xfer !== 16'd20) begin
            n_err++;
            $display("FAIL sat_count: sat_xfer=%0d full_xfer=%0d, required 15 / 20", c_xfer, a_xfer);
        end
        // Word accepted at one edge drains at the next, where clear is also high.
        @(posedge clk);
        #1;
        send(16'h3333, 2'd3);
        clear = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (c_out_valid !== 4'b1000) begin
            n_err++;
            $display("FAIL sat_drain_valid: ov=%b, required 1000", c_out_valid);
        end
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (c_xfer !== 4'd0 || c_out_valid !== 4'b0) begin
            n_err++;
            $display("FAIL sat_clear: xfer=%0d ov=%b, required 0 / 0000", c_xfer, c_out_valid);
        end
        wait_empty();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_bad_sel();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
